seg_display_driver: RTL and testbench

Output end of the calculator datapath: accepts an 8-bit two's-complement result and drives a 4-digit multiplexed common-anode 7-segment display. The block converts the result to sign-magnitude, runs a sequential double-dabble binary-to-BCD conversion, latches the digits, and continuously scans them. It is the display-side counterpart of the keypad capture, BCD-to-binary and sign-magnitude-to-two's-complement input path.

---
 rtl/calc_pkg.sv | 40 ++++
 rtl/seg7_decode.sv | 27 ++
 rtl/seg_display_driver.sv | 143 ++++++++++++++
 tb/tb_seg_display_driver.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator display definitions: segment patterns, digit codes, and
// the result-display FSM states.
package calc_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Digit code: 0-9 numeric, 4'hA minus sign, 4'hF blank
    typedef logic [3:0] digit_t;

    localparam digit_t DIG_MINUS = 4'hA;
    localparam digit_t DIG_BLANK = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_LATCH   = 2'd2
    } state_t;

    // One double-dabble iteration on {hundreds, tens, ones, binary}
    function automatic logic [19:0] dabble_step(input logic [19:0] v);
        logic [19:0] a;
        a = v;
        if (a[19:16] >= 4'd5) a[19:16] = a[19:16] + 4'd3;
        if (a[15:12] >= 4'd5) a[15:12] = a[15:12] + 4'd3;
        if (a[11:8]  >= 4'd5) a[11:8]  = a[11:8]  + 4'd3;
        return {a[18:0], 1'b0};
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Digit code to active-low {g,f,e,d,c,b,a} pattern; unused codes show blank.
module seg7_decode
    import calc_pkg::*;
(
    input  digit_t     digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:      seg = SEG_0;
            4'd1:      seg = SEG_1;
            4'd2:      seg = SEG_2;
            4'd3:      seg = SEG_3;
            4'd4:      seg = SEG_4;
            4'd5:      seg = SEG_5;
            4'd6:      seg = SEG_6;
            4'd7:      seg = SEG_7;
            4'd8:      seg = SEG_8;
            4'd9:      seg = SEG_9;
            DIG_MINUS: seg = SEG_MINUS;
            default:   seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_display_driver.sv
// Converts an 8-bit two's-complement result to sign + 3 BCD digits and scans
// them onto a 4-digit common-anode display.
//
// state      | meaning
// -----------+------------------------------------------------
// ST_IDLE    | waiting for LOAD; display shows last latched value
// ST_CONVERT | 8 shift-add-3 iterations, counted down by iter_q
// ST_LATCH   | copy BCD into display regs with blanking, pulse DONE
module seg_display_driver
    import calc_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [7:0] Result,
    input  logic       LOAD,
    output logic       BUSY,
    output logic       DONE,
    output logic [6:0] SEG,
    output logic [3:0] AN
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    state_t            state_q, state_d;
    logic [2:0]        iter_q, iter_d;
    logic [19:0]       bcd_q, bcd_d;
    logic              neg_q, neg_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    digit_t            sign_q, sign_d;
    digit_t            hund_q, hund_d;
    digit_t            tens_q, tens_d;
    digit_t            ones_q, ones_d;

    logic [CNT_W-1:0]  refresh_q, refresh_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              wrap;
    digit_t            scan_code;
    logic [6:0]        scan_pat;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            iter_q    <= '0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sign_q    <= DIG_BLANK;
            hund_q    <= DIG_BLANK;
            tens_q    <= DIG_BLANK;
            ones_q    <= DIG_BLANK;
            refresh_q <= '0;
            idx_q     <= 2'd0;
            an_q      <= 4'b1110;
            seg_q     <= SEG_BLANK;
        end else begin
            state_q   <= state_d;
            iter_q    <= iter_d;
            bcd_q     <= bcd_d;
            neg_q     <= neg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sign_q    <= sign_d;
            hund_q    <= hund_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        done_d  = 1'b0;
        sign_d  = sign_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        case (state_q)
            ST_IDLE: begin
                if (LOAD) begin
                    // 8-bit negate gives the same low byte as the 9-bit form, so -128 -> 128
                    neg_d   = Result[7];
                    bcd_d   = {12'd0, Result[7] ? (~Result + 8'd1) : Result};
                    iter_d  = 3'd7;
                    state_d = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                bcd_d = dabble_step(bcd_q);
                if (iter_q == 3'd0) state_d = ST_LATCH;
                else                iter_d  = iter_q - 3'd1;
            end
            ST_LATCH: begin
                sign_d  = neg_q ? DIG_MINUS : DIG_BLANK;
                hund_d  = (bcd_q[19:16] == 4'd0) ? DIG_BLANK : bcd_q[19:16];
                tens_d  = (bcd_q[19:16] == 4'd0 && bcd_q[15:12] == 4'd0) ? DIG_BLANK : bcd_q[15:12];
                ones_d  = bcd_q[11:8];
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // BUSY also covers the DONE cycle so a conversion reads as 10 cycles busy
        busy_d = (state_d != ST_IDLE) || done_d;
    end

    // Scanner: AN and SEG are both derived from idx_d so they change on the same edge
    always_comb begin
        wrap      = (refresh_q == CNT_W'(REFRESH_DIV - 1));
        refresh_d = wrap ? '0 : refresh_q + CNT_W'(1);
        idx_d     = wrap ? idx_q + 2'd1 : idx_q;
        an_d      = ~(4'b0001 << idx_d);
        case (idx_d)
            2'd0:    scan_code = ones_q;
            2'd1:    scan_code = tens_q;
            2'd2:    scan_code = hund_q;
            default: scan_code = sign_q;
        endcase
        seg_d = scan_pat;
    end

    seg7_decode u_seg7_decode (
        .digit (scan_code),
        .seg   (scan_pat)
    );

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign SEG  = seg_q;
    assign AN   = an_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver with a fast refresh divider.
module tb_seg_display_driver;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] Result = 8'h00;
    logic       LOAD = 1'b0;
    logic       BUSY, DONE;
    logic [6:0] SEG;
    logic [3:0] AN;

    int tests = 0;
    int fails = 0;
    logic [6:0] seen [4];

    seg_display_driver #(.REFRESH_DIV(4)) dut (
        .CLK    (CLK),
        .reset  (reset),
        .Result (Result),
        .LOAD   (LOAD),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .SEG    (SEG),
        .AN     (AN)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Samples 16 cycles (every digit visited) and records the pattern per enabled digit
    task automatic capture(input string tag);
        logic legal;
        for (int i = 0; i < 4; i++) seen[i] = 7'h55;
        for (int i = 0; i < 16; i++) begin
            legal = 1'b1;
            case (AN)
                4'b1110: seen[0] = SEG;
                4'b1101: seen[1] = SEG;
                4'b1011: seen[2] = SEG;
                4'b0111: seen[3] = SEG;
                default: legal = 1'b0;
            endcase
            chk({tag, "_an_legal"}, {7'd0, legal}, 8'd1);
            @(negedge CLK);
        end
    endtask

    task automatic check_display(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                                 input logic [6:0] e1, input logic [6:0] e0);
        capture(tag);
        chk({tag, "_sign"}, {1'b0, seen[3]}, {1'b0, e3});
        chk({tag, "_hund"}, {1'b0, seen[2]}, {1'b0, e2});
        chk({tag, "_tens"}, {1'b0, seen[1]}, {1'b0, e1});
        chk({tag, "_ones"}, {1'b0, seen[0]}, {1'b0, e0});
    endtask

    // LOAD sampled at edge N; checks {BUSY,DONE} after edges N..N+10
    task automatic run_load(input string tag, input logic [7:0] val);
        @(negedge CLK);
        Result = val;
        LOAD   = 1'b1;
        @(negedge CLK);
        LOAD   = 1'b0;
        chk({tag, "_bd_n0"}, {6'd0, BUSY, DONE}, 8'h02);
        for (int k = 1; k <= 9; k++) begin
            @(negedge CLK);
            chk($sformatf("%s_bd_n%0d", tag, k), {6'd0, BUSY, DONE}, (k == 9) ? 8'h03 : 8'h02);
        end
        @(negedge CLK);
        chk({tag, "_bd_n10"}, {6'd0, BUSY, DONE}, 8'h00);
    endtask

    initial begin
        int dcount;

        reset = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_an",   {4'd0, AN},  8'h0E);
        chk("rst_seg",  {1'b0, SEG}, 8'h7F);
        chk("rst_busy", {7'd0, BUSY}, 8'h00);
        chk("rst_done", {7'd0, DONE}, 8'h00);

        reset = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            logic [3:0] exp_an;
            @(negedge CLK);
            exp_an = ~(4'b0001 << ((k / 4) % 4));
            chk($sformatf("scan_an_%0d", k), {4'd0, AN}, {4'd0, exp_an});
            chk($sformatf("scan_seg_%0d", k), {1'b0, SEG}, 8'h7F);
            chk($sformatf("scan_busy_%0d", k), {7'd0, BUSY}, 8'h00);
        end

        run_load("m128", 8'h80);
        check_display("m128", 7'h3F, 7'h79, 7'h24, 7'h00);
        run_load("p127", 8'h7F);
        check_display("p127", 7'h7F, 7'h79, 7'h24, 7'h78);
        run_load("zero", 8'h00);
        check_display("zero", 7'h7F, 7'h7F, 7'h7F, 7'h40);
        run_load("m10", 8'hF6);
        check_display("m10", 7'h3F, 7'h7F, 7'h79, 7'h40);
        run_load("p5", 8'h05);
        check_display("p5", 7'h7F, 7'h7F, 7'h7F, 7'h12);

        // Second LOAD arrives mid-conversion and must be dropped
        @(negedge CLK);
        Result = 8'h01;
        LOAD   = 1'b1;
        @(negedge CLK);
        LOAD   = 1'b0;
        dcount = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (DONE) dcount++;
            if (k == 2) begin
                Result = 8'h02;
                LOAD   = 1'b1;
            end else if (k == 3) begin
                LOAD   = 1'b0;
            end
        end
        chk("ign_done_cnt", 8'(dcount), 8'd1);
        check_display("ign", 7'h7F, 7'h7F, 7'h7F, 7'h79);

        // Reset mid-conversion abandons it without DONE
        @(negedge CLK);
        Result = 8'h63;
        LOAD   = 1'b1;
        @(negedge CLK);
        LOAD   = 1'b0;
        repeat (3) @(negedge CLK);
        reset  = 1'b0;
        dcount = 0;
        repeat (2) begin
            @(negedge CLK);
            if (DONE) dcount++;
        end
        chk("rmid_busy_in_rst", {7'd0, BUSY}, 8'h00);
        reset = 1'b1;
        repeat (12) begin
            @(negedge CLK);
            if (DONE) dcount++;
        end
        chk("rmid_done_cnt", 8'(dcount), 8'd0);
        chk("rmid_busy", {7'd0, BUSY}, 8'h00);
        check_display("rmid", 7'h7F, 7'h7F, 7'h7F, 7'h7F);

        run_load("p99", 8'h63);
        check_display("p99", 7'h7F, 7'h7F, 7'h10, 7'h10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
